// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: FSM state encodings and the per-cycle enable/flush bundle.
// Imported by the hazard controller and by the pipeline-register blocks it drives.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_HOLD   = 6'b000000;
  localparam pipe_ctrl_t CTRL_FLOW   = 6'b111100;
  localparam pipe_ctrl_t CTRL_BRANCH = 6'b111111;
  // Load-use: freeze PC and IF/ID, turn the ID/EX slot into a bubble, let EX/MEM drain.
  localparam pipe_ctrl_t CTRL_BUBBLE = 6'b001101;

  // Priority: memory stall, then taken branch, then load-use.
  function automatic pipe_ctrl_t resolve_ctrl(input logic mem_stall,
                                              input logic branch_taken,
                                              input logic load_use);
    pipe_ctrl_t c;
    if (mem_stall) begin
      c = CTRL_HOLD;
    end else if (branch_taken) begin
      c = CTRL_BRANCH;
    end else if (load_use) begin
      c = CTRL_BUBBLE;
    end else begin
      c = CTRL_FLOW;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction reading the register a load in EX is about to write.
// Purely combinational; writes to x0 never create a hazard.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_wr_reg,
  input  logic                 ex_mem_read,
  output logic                 load_use
);

  logic rs1_hit;
  logic rs2_hit;
  logic wr_valid;

  always_comb begin
    wr_valid = ex_mem_read && (ex_wr_reg != '0);
    rs1_hit  = id_uses_rs1 && (id_rs1 == ex_wr_reg);
    rs2_hit  = id_uses_rs2 && (id_rs2 == ex_wr_reg);
    load_use = wr_valid && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: zero-latency enables/flushes from state and inputs; memory waits
// hold the whole pipe, and MEM_TIMEOUT consecutive stalled cycles lock it in ERR until reset.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_wr_reg,
  input  logic                 ex_mem_read,
  input  logic                 ex_branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_we,
  output logic                 ifid_we,
  output logic                 idex_we,
  output logic                 exmem_we,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic [1:0]           state_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o,
  output logic                 mem_err_o
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W:0] TIMEOUT_EXT = (WAIT_W + 1)'(MEM_TIMEOUT);

  pipe_state_e        state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               mem_err_q, mem_err_d;

  logic               load_use;
  logic               mem_stall;
  logic [WAIT_W:0]    wait_next;
  pipe_ctrl_t         ctrl;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_wr_reg   (ex_wr_reg),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // The wait counter counts stalled cycles including the RUN cycle that first saw the stall.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    ctrl       = CTRL_HOLD;
    wait_next  = {1'b0, wait_cnt_q} + (WAIT_W + 1)'(1);

    case (state_q)
      RUN, MEMWAIT: begin
        ctrl = resolve_ctrl(mem_stall, ex_branch_taken, load_use);
        if (mem_stall) begin
          if (wait_next >= TIMEOUT_EXT) begin
            state_d    = ERR;
            mem_err_d  = 1'b1;
            wait_cnt_d = '0;
          end else begin
            state_d    = MEMWAIT;
            wait_cnt_d = wait_next[WAIT_W-1:0];
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      ERR: begin
        mem_err_d = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (rst) begin
      ctrl = CTRL_HOLD;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ctrl.pc_we && (state_q != ERR) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (ctrl.ifid_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  assign pc_we       = ctrl.pc_we;
  assign ifid_we     = ctrl.ifid_we;
  assign idex_we     = ctrl.idex_we;
  assign exmem_we    = ctrl.exmem_we;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign mem_err_o   = mem_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Two controllers (default sizing, and CNT_W=2 / MEM_TIMEOUT=4) driven with identical stimulus.
// Directed scenarios pin exact values; a per-cycle reference model checks every output.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_wr_reg = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b0;

  logic        pc_we_a, ifid_we_a, idex_we_a, exmem_we_a, ifid_flush_a, idex_flush_a, mem_err_a;
  logic [1:0]  state_a;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic        pc_we_b, ifid_we_b, idex_we_b, exmem_we_b, ifid_flush_b, idex_flush_b, mem_err_b;
  logic [1:0]  state_b;
  logic [1:0]  stall_cnt_b, flush_cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(16), .MEM_TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_wr_reg(ex_wr_reg),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we_a), .ifid_we(ifid_we_a), .idex_we(idex_we_a), .exmem_we(exmem_we_a),
    .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a), .state_o(state_a),
    .stall_cnt_o(stall_cnt_a), .flush_cnt_o(flush_cnt_a), .mem_err_o(mem_err_a)
  );

  pipe_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_wr_reg(ex_wr_reg),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we_b), .ifid_we(ifid_we_b), .idex_we(idex_we_b), .exmem_we(exmem_we_b),
    .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b), .state_o(state_b),
    .stall_cnt_o(stall_cnt_b), .flush_cnt_o(flush_cnt_b), .mem_err_o(mem_err_b)
  );

  logic [5:0] ctl_a, ctl_b;
  assign ctl_a = {pc_we_a, ifid_we_a, idex_we_a, exmem_we_a, ifid_flush_a, idex_flush_a};
  assign ctl_b = {pc_we_b, ifid_we_b, idex_we_b, exmem_we_b, ifid_flush_b, idex_flush_b};

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: per instance, a count of consecutive stalled cycles, an error latch and event totals.
  int m_wait[2]  = '{0, 0};
  bit m_err[2]   = '{0, 0};
  int m_stall[2] = '{0, 0};
  int m_flush[2] = '{0, 0};
  int tmo[2]     = '{255, 4};
  int cmax[2]    = '{65535, 3};

  bit         mdl_lu, mdl_ms;
  logic [5:0] exp_ctl;
  int         exp_state;
  string      pfx;

  always @(negedge clk) begin
    mdl_lu = ex_mem_read && (ex_wr_reg != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_wr_reg) || (id_uses_rs2 && id_rs2 == ex_wr_reg));
    mdl_ms = mem_req && !mem_ready;
    for (int k = 0; k < 2; k++) begin
      pfx = (k == 0) ? "A" : "B";
      if (rst) begin
        m_wait[k] = 0; m_err[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end
      if (rst || m_err[k] || mdl_ms) exp_ctl = 6'b000000;
      else if (ex_branch_taken)       exp_ctl = 6'b111111;
      else if (mdl_lu)                exp_ctl = 6'b001101;
      else                            exp_ctl = 6'b111100;
      exp_state = m_err[k] ? 2 : ((m_wait[k] > 0) ? 1 : 0);

      chk({pfx, ".ctl"},     int'(k == 0 ? ctl_a : ctl_b), int'(exp_ctl));
      chk({pfx, ".state"},   int'(k == 0 ? state_a : state_b), exp_state);
      chk({pfx, ".mem_err"}, int'(k == 0 ? mem_err_a : mem_err_b), int'(m_err[k]));
      chk({pfx, ".stall"},   (k == 0) ? int'(stall_cnt_a) : int'(stall_cnt_b), m_stall[k]);
      chk({pfx, ".flush"},   (k == 0) ? int'(flush_cnt_a) : int'(flush_cnt_b), m_flush[k]);

      if (!rst) begin
        if (!m_err[k]) begin
          if (!exp_ctl[5] && m_stall[k] < cmax[k]) m_stall[k]++;
          if (mdl_ms) begin
            m_wait[k]++;
            if (m_wait[k] >= tmo[k]) m_err[k] = 1;
          end else begin
            m_wait[k] = 0;
          end
        end
        if (exp_ctl[1] && m_flush[k] < cmax[k]) m_flush[k]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_wr_reg = 0; ex_mem_read = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic load_use_in(input logic [4:0] wr);
    idle();
    ex_mem_read = 1; ex_wr_reg = wr; id_rs1 = 5; id_uses_rs1 = 1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1;
    idle();
    tick();
    tick();
    rst = 0;
  endtask

  bit hold_req, hold_rdy;

  initial begin
    idle();
    tick();
    tick();
    #3;
    chk("reset.state", state_a, 0);
    chk("reset.ctl", ctl_a, 0);
    chk("reset.stall", stall_cnt_a, 0);
    chk("reset.mem_err", mem_err_b, 0);
    rst = 0;

    // Load-use bubble lasts exactly one cycle once ID/EX has been bubbled.
    do_reset();
    load_use_in(5);
    #3;
    chk("lu.pc_we", pc_we_a, 0);
    chk("lu.ifid_we", ifid_we_a, 0);
    chk("lu.idex_flush", idex_flush_a, 1);
    chk("lu.exmem_we", exmem_we_a, 1);
    tick();
    idle();
    #3;
    chk("lu.next_pc_we", pc_we_a, 1);
    chk("lu.stall_cnt", stall_cnt_a, 1);

    // Load into x0 is not a hazard.
    load_use_in(0);
    #3;
    chk("x0.ctl", ctl_a, 6'b111100);
    tick();
    idle();

    // Branch wins over load-use.
    do_reset();
    load_use_in(5);
    ex_branch_taken = 1;
    #3;
    chk("br.ctl", ctl_a, 6'b111111);
    tick();
    idle();
    #3;
    chk("br.flush_cnt", flush_cnt_a, 1);
    chk("br.stall_cnt", stall_cnt_a, 0);

    // Three memory-wait cycles, then completion.
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("mw.ctl", ctl_a, 0);
      if (i > 0) chk("mw.state", state_a, 1);
      tick();
    end
    mem_ready = 1;
    #3;
    chk("mw.ready_state", state_a, 1);
    chk("mw.ready_ctl", ctl_a, 6'b111100);
    tick();
    idle();
    #3;
    chk("mw.back_run", state_a, 0);
    chk("mw.stall_cnt", stall_cnt_a, 3);
    chk("mw.b_no_err", state_b, 0);

    // Timeout on the MEM_TIMEOUT=4 instance; ERR is sticky until reset.
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (4) tick();
    #3;
    chk("to.state", state_b, 2);
    chk("to.mem_err", mem_err_b, 1);
    chk("to.a_waiting", state_a, 1);
    mem_ready = 1;
    tick();
    #3;
    chk("to.sticky_state", state_b, 2);
    chk("to.sticky_err", mem_err_b, 1);
    chk("to.err_ctl", ctl_b, 0);
    chk("to.stall_sat", stall_cnt_b, 3);
    tick();
    rst = 1;
    idle();
    #3;
    chk("to.rst_state", state_b, 0);
    chk("to.rst_err", mem_err_b, 0);
    chk("to.rst_stall", stall_cnt_b, 0);
    tick();
    rst = 0;

    // Five load-use stalls saturate a 2-bit counter.
    do_reset();
    repeat (5) begin
      load_use_in(5);
      tick();
      idle();
      tick();
    end
    #3;
    chk("sat.b_stall", stall_cnt_b, 3);
    chk("sat.a_stall", stall_cnt_a, 5);

    // Randomized phase: sticky memory handshake so stall bursts and timeouts occur.
    hold_req = 0;
    hold_rdy = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst             = ($urandom_range(0, 59) == 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_wr_reg       = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) < 3) hold_req = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 3) hold_rdy = 1'($urandom_range(0, 1));
      mem_req   = hold_req;
      mem_ready = hold_rdy;
    end
    tick();
    rst = 0;
    idle();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255: maximum number of consecutive memory-wait cycles before the error state.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports id_rs1 and id_rs2, input, 5 each: ID-stage source register indices.
REQ-006 SHALL have ports id_uses_rs1 and id_uses_rs2, input, 1 each: ID instruction reads rs1 / rs2.
REQ-007 SHALL have port ex_wr_reg, input, 5: destination register held in ID/EX.
REQ-008 SHALL have port ex_mem_read, input, 1: ID/EX holds a load.
REQ-009 SHALL have port ex_branch_taken, input, 1: branch or jump resolved taken in EX.
REQ-010 SHALL have ports mem_req and mem_ready, input, 1 each: data-memory request and completion.
REQ-011 SHALL have ports pc_we, ifid_we, idex_we and exmem_we, output, 1 each: pipeline-register write enables.
REQ-012 SHALL have ports ifid_flush and idex_flush, output, 1 each: load a bubble (all-zero control) into the register.
REQ-013 SHALL have port state_o, output, 2: FSM state encoding, RUN=0, MEMWAIT=1, ERR=2.
REQ-014 SHALL have ports stall_cnt_o and flush_cnt_o, output, CNT_W each: saturating event counters.
REQ-015 SHALL have port mem_err_o, output, 1: sticky memory-timeout flag.

Function
REQ-016 SHALL define load_use = ex_mem_read & (ex_wr_reg!=0) & ((id_uses_rs1 & id_rs1==ex_wr_reg) | (id_uses_rs2 & id_rs2==ex_wr_reg)).
REQ-017 SHALL define mem_stall = mem_req & ~mem_ready.
REQ-018 SHALL generate all enables and flushes combinationally from the current state and the inputs, with zero-cycle latency.
REQ-019 In RUN, when mem_stall is true, SHALL drive all four write enables 0, drive both flushes 0, and enter MEMWAIT at the next edge. Mem stall has priority over branch and load-use.
REQ-020 In RUN, when there is no mem_stall and ex_branch_taken is true, SHALL drive all write enables 1, ifid_flush=1 and idex_flush=1. A branch has priority over load-use.
REQ-021 In RUN, when there is no mem_stall, no branch, and load_use is true, SHALL drive pc_we=0, ifid_we=0, idex_we=1, idex_flush=1, ifid_flush=0 and exmem_we=1, inserting exactly one bubble.
REQ-022 In RUN with no events, SHALL drive all write enables 1 and both flushes 0.
REQ-023 In MEMWAIT, SHALL keep all enables 0 while mem_stall holds, and SHALL increment an internal wait counter each cycle.
REQ-024 In MEMWAIT, when mem_ready=1, SHALL evaluate the same cycle as RUN (branch and load-use apply), return to RUN, and clear the wait counter.
REQ-025 When the wait counter reaches MEM_TIMEOUT while still stalled, SHALL enter ERR and set mem_err_o.
REQ-026 ERR SHALL be terminal until rst: all enables 0, flushes 0, mem_err_o=1.
REQ-027 stall_cnt_o SHALL increment on every cycle with pc_we=0 outside ERR, and SHALL saturate at all-ones.
REQ-028 flush_cnt_o SHALL increment on every cycle with ifid_flush=1, and SHALL saturate at all-ones.

Reset
REQ-029 While rst=1, SHALL force state RUN, wait counter 0, stall_cnt_o=0, flush_cnt_o=0 and mem_err_o=0, with all enables 0 and flushes 0.
REQ-030 Reset asserted mid-MEMWAIT or in ERR SHALL take effect immediately (asynchronously). The first cycle after deassertion SHALL be RUN.

Structure
REQ-031 SHALL place the state encodings RUN, MEMWAIT and ERR in a shared pipeline package used by the pipeline-register blocks.
REQ-032 SHALL be a single FSM with a separate sub-module hazard_detect computing load_use combinationally.

Verification
REQ-033 SHALL cover load-use: ex_mem_read=1, ex_wr_reg=5, id_rs1=5, id_uses_rs1=1 -> pc_we=0, ifid_we=0, idex_flush=1 for exactly 1 cycle; stall_cnt_o=1.
REQ-034 SHALL cover x0 write: the same stimulus with ex_wr_reg=0 -> no stall, all enables 1.
REQ-035 SHALL cover branch combined with load-use: ex_branch_taken=1 together with a load-use hazard -> ifid_flush=idex_flush=1, pc_we=1; flush_cnt_o=1.
REQ-036 SHALL cover memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> enables 0 for 3 cycles, state_o=1, then RUN; stall_cnt_o=3.
REQ-037 SHALL cover timeout: mem_ready held 0 with MEM_TIMEOUT=4 -> ERR reached, mem_err_o=1 and sticky; rst pulse -> state_o=0, counters 0.
REQ-038 SHALL cover saturation: CNT_W=2 with 5 load-use stalls -> stall_cnt_o=3.
